// File: rtl/param_stream_router_if.sv
// Stream-router bus: one producer-side input stream and NUM_OUT consumer-side output lanes.
//
//   din         producer payload
//   din_valid   producer beat present
//   din_addr    destination channel index
//   din_bcast   (only with ROUTER_BCAST_EN) push this beat into every channel
//   din_ready   router accepts the beat this cycle
//   dout        flattened lanes, lane i = dout[i*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid  per-lane valid
//   dout_ready  per-lane consumer ready
//   drop_pulse  one-cycle pulse after an out-of-range beat is discarded
//
// Modport slave is the router side; master is the producer/consumer side.
interface param_stream_router_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_OUT)
);
  logic [DATA_WIDTH-1:0]         din;
  logic                          din_valid;
  logic [ADDR_WIDTH-1:0]         din_addr;
`ifdef ROUTER_BCAST_EN
  logic                          din_bcast;
`endif
  logic                          din_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0] dout;
  logic [NUM_OUT-1:0]            dout_valid;
  logic [NUM_OUT-1:0]            dout_ready;
  logic                          drop_pulse;

  modport slave (
    input  din,
    input  din_valid,
    input  din_addr,
`ifdef ROUTER_BCAST_EN
    input  din_bcast,
`endif
    output din_ready,
    output dout,
    output dout_valid,
    input  dout_ready,
    output drop_pulse
  );

  modport master (
    output din,
    output din_valid,
    output din_addr,
`ifdef ROUTER_BCAST_EN
    output din_bcast,
`endif
    input  din_ready,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  drop_pulse
  );
endinterface

// File: rtl/param_stream_router.sv
// Parametrised 1-to-NUM_OUT stream router with a DEPTH-entry FIFO per output channel.
// A stalled consumer only back-pressures beats addressed to its own channel, and only once
// that channel's FIFO is full.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset; discards all buffered data
//   bus    param_stream_router_if.slave (input stream, output lanes, drop_pulse)
//
// Optional feature: define ROUTER_BCAST_EN to add din_bcast, which pushes a beat into all
// channels at once (accepted only when no channel is full).
module param_stream_router #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_OUT)
) (
  input logic                 clk,
  input logic                 reset,
  param_stream_router_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_OUT][DEPTH];
  logic [PtrW-1:0]       wr_ptr_q [NUM_OUT];
  logic [PtrW-1:0]       wr_ptr_d [NUM_OUT];
  logic [PtrW-1:0]       rd_ptr_q [NUM_OUT];
  logic [PtrW-1:0]       rd_ptr_d [NUM_OUT];
  logic [CntW-1:0]       count_q  [NUM_OUT];
  logic [CntW-1:0]       count_d  [NUM_OUT];

  logic [NUM_OUT-1:0]    full;
  logic [NUM_OUT-1:0]    out_valid;
  logic [NUM_OUT-1:0]    addr_hit;
  logic [NUM_OUT-1:0]    push;
  logic [NUM_OUT-1:0]    pop;
  logic                  addr_in_range;
  logic                  sel_full;
  logic                  bcast;
  logic                  in_ready;
  logic                  accept;
  logic                  drop_d;
  logic                  drop_q;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_data;

`ifdef ROUTER_BCAST_EN
  assign bcast = bus.din_valid & bus.din_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Channel status straight from the occupancy counters.
  always_comb begin
    full      = '0;
    out_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      full[i]      = (count_q[i] == CntFull);
      out_valid[i] = (count_q[i] != '0);
    end
  end

  // Address decode; an address matching no channel is out of range (non-power-of-two NUM_OUT).
  always_comb begin
    addr_hit      = '0;
    addr_in_range = 1'b0;
    sel_full      = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (bus.din_addr == ADDR_WIDTH'(i)) begin
        addr_hit[i]   = 1'b1;
        addr_in_range = 1'b1;
        sel_full      = full[i];
      end
    end
  end

  // Readiness looks only at the current counts, so a full channel is never refilled in the
  // same cycle it pops.
  always_comb begin
    if (bcast) begin
      in_ready = ~|full;
    end else if (addr_in_range) begin
      in_ready = ~sel_full;
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = bus.din_valid & in_ready;
  assign push   = (bcast ? {NUM_OUT{1'b1}} : addr_hit) & {NUM_OUT{accept}};
  assign pop    = out_valid & bus.dout_ready;
  assign drop_d = accept & ~bcast & ~addr_in_range;

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
      count_d[i]  = count_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CntW'(1);
        2'b01:   count_d[i] = count_q[i] - CntW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      count_q  <= '{default: '0};
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: lanes are gated by valid, which comes from the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= bus.din;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (out_valid[i]) begin
        out_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign bus.din_ready  = in_ready;
  assign bus.dout       = out_data;
  assign bus.dout_valid = out_valid;
  assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_param_stream_router.sv
module tb_param_stream_router;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  param_stream_router_if #(.DATA_WIDTH(32), .NUM_OUT(4)) bus4 ();
  param_stream_router_if #(.DATA_WIDTH(32), .NUM_OUT(3)) bus3 ();

  param_stream_router #(.DATA_WIDTH(32), .NUM_OUT(4), .DEPTH(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  param_stream_router #(.DATA_WIDTH(32), .NUM_OUT(3), .DEPTH(4)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane4(input int i);
    return bus4.dout[i*32 +: 32];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus4.din = '0; bus4.din_valid = 1'b0; bus4.din_addr = '0; bus4.dout_ready = '0;
    bus3.din = '0; bus3.din_valid = 1'b0; bus3.din_addr = '0; bus3.dout_ready = '0;
`ifdef ROUTER_BCAST_EN
    bus4.din_bcast = 1'b0;
    bus3.din_bcast = 1'b0;
`endif
    #3;
    check("rst_valid", bus4.dout_valid, 0);
    check("rst_dout", bus4.dout, 0);
    check("rst_drop", bus4.drop_pulse, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_ready", bus4.din_ready, 1);

    // Single beat to channel 2.
    bus4.din = 32'hA5A5_0001; bus4.din_addr = 2'd2; bus4.din_valid = 1'b1;
    #1;
    check("single_ready", bus4.din_ready, 1);
    step();
    bus4.din_valid = 1'b0;
    #1;
    check("single_valid", bus4.dout_valid, 4'b0100);
    check("single_dout", bus4.dout, 128'h0000_0000_A5A5_0001_0000_0000_0000_0000);
    bus4.dout_ready = 4'b0100;
    step();
    check("single_clear", bus4.dout_valid, 0);

    // Fill channel 1 while its consumer stalls.
    bus4.dout_ready = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      bus4.din = 32'(k); bus4.din_addr = 2'd1; bus4.din_valid = 1'b1;
      #1;
      check("fill_ready", bus4.din_ready, 1);
      step();
    end
    bus4.din = 32'd5;
    #1;
    check("full_ready", bus4.din_ready, 0);
    bus4.din = 32'h100; bus4.din_addr = 2'd0;
    #1;
    check("ch0_while_full", bus4.din_ready, 1);
    step();
    check("full_valid", bus4.dout_valid, 4'b0011);
    check("full_lane1", lane4(1), 32'd1);
    check("full_lane0", lane4(0), 32'h100);
    bus4.din = 32'd5; bus4.din_addr = 2'd1; bus4.dout_ready = 4'b0010;
    #1;
    check("no_refill", bus4.din_ready, 0);
    step();
    check("after_pop_ready", bus4.din_ready, 1);
    check("pop_lane1_2", lane4(1), 32'd2);
    step();
    bus4.din_valid = 1'b0;
    check("pop_lane1_3", lane4(1), 32'd3);
    step();
    check("pop_lane1_4", lane4(1), 32'd4);
    step();
    check("pop_lane1_5", lane4(1), 32'd5);
    step();
    check("ch1_empty", bus4.dout_valid, 4'b0001);
    bus4.dout_ready = 4'b0001;
    check("ch0_lane", lane4(0), 32'h100);
    step();
    check("ch0_empty", bus4.dout_valid, 0);

    // Channel 3: steady push+pop at occupancy 2, wrapping the pointers several times.
    bus4.dout_ready = 4'b0000;
    bus4.din_addr = 2'd3; bus4.din_valid = 1'b1;
    bus4.din = 32'd10;
    step();
    bus4.din = 32'd11;
    step();
    for (int c = 0; c < 10; c++) begin
      bus4.din = 32'(12 + c); bus4.dout_ready = 4'b1000;
      #1;
      check("pp_lane3", lane4(3), 32'(10 + c));
      check("pp_ready", bus4.din_ready, 1);
      step();
    end
    bus4.din_valid = 1'b0;
    check("pp_valid", bus4.dout_valid, 4'b1000);
    check("pp_tail20", lane4(3), 32'd20);
    step();
    check("pp_tail21", lane4(3), 32'd21);
    step();
    check("pp_empty", bus4.dout_valid, 0);

    // Reset with data buffered in channel 0.
    bus4.dout_ready = 4'b0000;
    bus4.din_addr = 2'd0; bus4.din_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus4.din = 32'h30 + 32'(k);
      step();
    end
    bus4.din_valid = 1'b0;
    check("mid_valid", bus4.dout_valid, 4'b0001);
    reset = 1'b1;
    #1;
    check("async_valid", bus4.dout_valid, 0);
    check("async_dout", bus4.dout, 0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_valid", bus4.dout_valid, 0);
    bus4.din = 32'h40; bus4.din_valid = 1'b1;
    step();
    bus4.din_valid = 1'b0;
    check("post_rst_beat_valid", bus4.dout_valid, 4'b0001);
    check("post_rst_beat_lane", lane4(0), 32'h40);
    bus4.dout_ready = 4'b0001;
    step();
    bus4.dout_ready = 4'b0000;
    check("post_rst_drain", bus4.dout_valid, 0);

    // Out-of-range address on the 3-channel instance.
    bus3.din = 32'hBAD; bus3.din_addr = 2'd3; bus3.din_valid = 1'b1;
    #1;
    check("drop_ready", bus3.din_ready, 1);
    check("drop_pre", bus3.drop_pulse, 0);
    step();
    bus3.din_valid = 1'b0;
    check("drop_pulse", bus3.drop_pulse, 1);
    check("drop_novalid", bus3.dout_valid, 0);
    step();
    check("drop_one_cycle", bus3.drop_pulse, 0);
    bus3.din = 32'h77; bus3.din_addr = 2'd2; bus3.din_valid = 1'b1;
    step();
    bus3.din_valid = 1'b0;
    check("n3_valid", bus3.dout_valid, 3'b100);
    check("n3_lane2", bus3.dout[64 +: 32], 32'h77);
    check("n3_nodrop", bus3.drop_pulse, 0);

`ifdef ROUTER_BCAST_EN
    bus4.din = 32'hDEAD_BEEF; bus4.din_bcast = 1'b1; bus4.din_valid = 1'b1;
    #1;
    check("bc_ready", bus4.din_ready, 1);
    step();
    bus4.din_valid = 1'b0; bus4.din_bcast = 1'b0;
    check("bc_valid", bus4.dout_valid, 4'b1111);
    check("bc_dout", bus4.dout, {4{32'hDEAD_BEEF}});
    check("bc_nodrop", bus4.drop_pulse, 0);
    bus4.dout_ready = 4'b1111;
    step();
    bus4.dout_ready = 4'b0000;
    check("bc_drained", bus4.dout_valid, 0);
    bus4.din_addr = 2'd2; bus4.din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus4.din = 32'h200 + 32'(k);
      step();
    end
    bus4.din = 32'hCAFE_0001; bus4.din_bcast = 1'b1;
    #1;
    check("bc_blocked", bus4.din_ready, 0);
    bus4.dout_ready = 4'b0100;
    #1;
    check("bc_blocked_pop", bus4.din_ready, 0);
    step();
    check("bc_unblocked", bus4.din_ready, 1);
    step();
    bus4.din_valid = 1'b0; bus4.din_bcast = 1'b0; bus4.dout_ready = 4'b0000;
    check("bc_all_valid", bus4.dout_valid, 4'b1111);
    check("bc_lane0", lane4(0), 32'hCAFE_0001);
    check("bc_lane2_head", lane4(2), 32'h202);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
